// File: rtl/mem_target_responder.sv
// rtl/mem_target_responder.sv - single-request memory responder with fixed wait states and register-file storage
module mem_target_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_ack,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int              WAIT_LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0]      WAIT_LAST   = WAIT_LAST_I[3:0];
    localparam logic [ADDR_W:0] DEPTH_W     = DEPTH[ADDR_W:0];

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                cur_we;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic                cur_mapped;
    logic                do_access;
    logic [DATA_W-1:0]   rd_word;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With no wait states the access completes straight out of IDLE, before the
    // request fields have been latched, so take them from the live inputs there.
    always_comb begin
        cur_we    = lat_we;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    assign cur_mapped = ({1'b0, cur_addr} < DEPTH_W);
    assign do_access  = (state_nxt == ST_ACK) && (state != ST_ACK);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cur_addr == i[ADDR_W-1:0]) begin
                rd_word = mem[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_valid) begin
                cnt       <= '0;
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_access && cur_we && cur_mapped && cur_addr == i[ADDR_W-1:0]) begin
                    mem[i] <= cur_wdata;
                end
            end
        end
    end

    // Read data is sticky: writes and idle cycles leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_ack   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_ack <= do_access;
            rsp_err <= do_access && !cur_mapped;
            if (do_access && !cur_we) begin
                rsp_rdata <= cur_mapped ? rd_word : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_target_responder.sv
// tb/tb_mem_target_responder.sv - self-checking bench for mem_target_responder (WAIT_CYCLES 2 and 0)
module tb_mem_target_responder;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          a_valid, a_we, a_ack, a_err, a_busy;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_we, b_ack, b_err, b_busy;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;

    int n_vec = 0;
    int n_err = 0;

    bit [7:0] model [2][16];
    bit [7:0] model_rd [2];
    int       wc [2];

    always #5 clk = ~clk;

    mem_target_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
        .req_wdata(a_wdata), .rsp_ack(a_ack), .rsp_err(a_err), .rsp_rdata(a_rdata), .busy(a_busy)
    );

    mem_target_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
        .req_wdata(b_wdata), .rsp_ack(b_ack), .rsp_err(b_err), .rsp_rdata(b_rdata), .busy(b_busy)
    );

    typedef struct {
        int       d;
        logic     we;
        logic [3:0] addr;
        logic [7:0] wdata;
        bit       garble;
        logic     exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic we, input logic [3:0] addr, input logic [7:0] wd);
        if (d == 0) begin
            a_valid = v; a_we = we; a_addr = addr; a_wdata = wd;
        end else begin
            b_valid = v; b_we = we; b_addr = addr; b_wdata = wd;
        end
    endtask

    task automatic sample(input int d, output logic ack, output logic err, output logic [7:0] rd, output logic bz);
        if (d == 0) begin
            ack = a_ack; err = a_err; rd = a_rdata; bz = a_busy;
        end else begin
            ack = b_ack; err = b_err; rd = b_rdata; bz = b_busy;
        end
    endtask

    task automatic model_step(input int d, input logic we, input logic [3:0] addr, input logic [7:0] wd,
                              output logic err, output logic [7:0] rd);
        err = (int'(addr) >= DEPTH);
        if (we && !err) model[d][addr] = wd;
        if (!we) model_rd[d] = err ? 8'h00 : model[d][addr];
        rd = model_rd[d];
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            model_rd[d] = 8'h00;
            for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
        end
    endtask

    // One complete access: accept, wc[d] wait cycles, one ack cycle, back to idle.
    task automatic transact(input int d, input logic we, input logic [3:0] addr, input logic [7:0] wd,
                            input bit garble, input logic exp_err, input logic [7:0] exp_rd);
        logic ack, err, bz;
        logic [7:0] rd;
        @(negedge clk);
        drive(d, 1'b1, we, addr, wd);
        @(posedge clk);
        for (int k = 1; k <= wc[d] + 1; k++) begin
            @(negedge clk);
            sample(d, ack, err, rd, bz);
            chk($sformatf("d%0d_busy_k%0d", d, k), {31'b0, bz}, 32'd1);
            if (k <= wc[d]) begin
                chk($sformatf("d%0d_ack_wait_k%0d", d, k), {31'b0, ack}, 32'd0);
                chk($sformatf("d%0d_err_wait_k%0d", d, k), {31'b0, err}, 32'd0);
            end else begin
                chk($sformatf("d%0d_ack a=%0d", d, addr), {31'b0, ack}, 32'd1);
                chk($sformatf("d%0d_err a=%0d", d, addr), {31'b0, err}, {31'b0, exp_err});
                chk($sformatf("d%0d_rdata a=%0d", d, addr), {24'b0, rd}, {24'b0, exp_rd});
            end
            if (garble && k <= wc[d])
                drive(d, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
            else
                drive(d, 1'b0, 1'b0, 4'h0, 8'h00);
        end
        @(negedge clk);
        sample(d, ack, err, rd, bz);
        chk($sformatf("d%0d_idle_busy", d), {31'b0, bz}, 32'd0);
        chk($sformatf("d%0d_idle_ack", d), {31'b0, ack}, 32'd0);
        chk($sformatf("d%0d_idle_err", d), {31'b0, err}, 32'd0);
    endtask

    initial begin
        logic       e_err;
        logic [7:0] e_rd;
        int         d;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wd;

        wc[0] = 2;
        wc[1] = 0;
        model_clear();
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00);

        tbl[0]  = '{0, 1'b0, 4'd5,  8'h00, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{0, 1'b1, 4'd3,  8'hA5, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{0, 1'b0, 4'd3,  8'h00, 1'b1, 1'b0, 8'hA5};
        tbl[3]  = '{0, 1'b1, 4'd13, 8'h77, 1'b0, 1'b1, 8'hA5};
        tbl[4]  = '{0, 1'b0, 4'd13, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[5]  = '{0, 1'b0, 4'd3,  8'h00, 1'b0, 1'b0, 8'hA5};
        tbl[6]  = '{0, 1'b0, 4'd11, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{0, 1'b1, 4'd7,  8'h11, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1, 1'b1, 4'd0,  8'h3C, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h3C};
        tbl[10] = '{1, 1'b0, 4'd15, 8'h00, 1'b0, 1'b1, 8'h00};
        tbl[11] = '{1, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h3C};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ack", {31'b0, a_ack}, 32'd0);
        chk("rst_a_err", {31'b0, a_err}, 32'd0);
        chk("rst_a_rdata", {24'b0, a_rdata}, 32'd0);
        chk("rst_a_busy", {31'b0, a_busy}, 32'd0);
        chk("rst_b_ack", {31'b0, b_ack}, 32'd0);
        chk("rst_b_err", {31'b0, b_err}, 32'd0);
        chk("rst_b_rdata", {24'b0, b_rdata}, 32'd0);
        chk("rst_b_busy", {31'b0, b_busy}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            model_step(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, e_err, e_rd);
            transact(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].garble,
                     tbl[i].exp_err, tbl[i].exp_rd);
        end

        for (int i = 0; i < 60; i++) begin
            d    = int'($urandom_range(0, 1));
            we   = 1'($urandom);
            addr = 4'($urandom);
            wd   = 8'($urandom);
            model_step(d, we, addr, wd, e_err, e_rd);
            transact(d, we, addr, wd, bit'($urandom), e_err, e_rd);
        end

        // Held request with no wait states: one ack every second cycle.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 4'd0, 8'h00);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("b_stream_ack_k%0d", k), {31'b0, b_ack}, {31'b0, (k % 2 == 1)});
            if (k == 8) drive(1, 1'b0, 1'b0, 4'd0, 8'h00);
        end
        model_step(1, 1'b0, 4'd0, 8'h00, e_err, e_rd);
        chk("b_stream_rdata", {24'b0, b_rdata}, {24'b0, e_rd});
        @(negedge clk);
        chk("b_stream_idle", {31'b0, b_busy}, 32'd0);

        // Reset while a write to @7 is waiting.
        transact(0, 1'b1, 4'd7, 8'h5A, 1'b0, 1'b0, model_rd[0]);
        model[0][7] = 8'h5A;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'd7, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 4'd0, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, a_busy}, 32'd0);
        chk("midrst_ack", {31'b0, a_ack}, 32'd0);
        chk("midrst_rdata", {24'b0, a_rdata}, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_noack_k%0d", k), {31'b0, a_ack}, 32'd0);
        end
        model_step(0, 1'b0, 4'd7, 8'h00, e_err, e_rd);
        transact(0, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 8'h00);
        model_step(1, 1'b0, 4'd0, 8'h00, e_err, e_rd);
        transact(1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
